// File: rtl/test_status_monitor.sv
// rtl/test_status_monitor.sv - test-completion monitor: shadows x26/x27/x3, declares pass/fail/timeout, counts stats
module test_status_monitor #(
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int TNUM_REG       = 3,
    parameter int DRAIN_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic             retire,
    input  logic             jump,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [31:0]      fail_testnum,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [CNT_W-1:0] jump_count
);

    localparam logic [4:0]       DONE_IDX   = 5'(DONE_REG);
    localparam logic [4:0]       PASS_IDX   = 5'(PASS_REG);
    localparam logic [4:0]       TNUM_IDX   = 5'(TNUM_REG);
    localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pass_sh;
    logic [31:0] tnum_sh;
    logic [31:0] drain_cnt;

    logic        wr;
    logic        done_wr;
    logic        drain_last;
    logic        to_hit;
    logic        active;
    logic        enter_final;
    logic [31:0] pass_eff;
    logic [31:0] tnum_eff;

    // Decode the write-back port; the verdict sees a same-edge write to the pass/test-number registers
    always_comb begin
        wr          = wb_en && (wb_addr != 5'd0);
        done_wr     = wr && (wb_addr == DONE_IDX) && (wb_data == 32'h1);
        pass_eff    = (wr && (wb_addr == PASS_IDX)) ? wb_data : pass_sh;
        tnum_eff    = (wr && (wb_addr == TNUM_IDX)) ? wb_data : tnum_sh;
        drain_last  = (drain_cnt == DRAIN_LAST);
        to_hit      = (cycle_count == TO_LAST);
        active      = (state == S_RUN) || (state == S_DRAIN);
        enter_final = active && ((state_next == S_PASS) || (state_next == S_FAIL) ||
                                 (state_next == S_TIMEOUT));
    end

    // Next-state logic; done beats timeout on the same edge, clr overrides everything
    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (done_wr) begin
                    state_next = S_DRAIN;
                end else if (to_hit) begin
                    state_next = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_next = (pass_eff == 32'h1) ? S_PASS : S_FAIL;
                end
            end
            default: state_next = state;
        endcase
        if (clr) begin
            state_next = S_RUN;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Registered verdict flags, loaded from the state being entered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
            done    <= 1'b0;
        end else begin
            pass    <= (state_next == S_PASS);
            fail    <= (state_next == S_FAIL);
            timeout <= (state_next == S_TIMEOUT);
            done    <= (state_next == S_PASS) || (state_next == S_FAIL) ||
                       (state_next == S_TIMEOUT);
        end
    end

    // Shadow copies of the pass-flag and test-number registers; x0 writes never land
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pass_sh <= 32'd0;
            tnum_sh <= 32'd0;
        end else if (clr) begin
            pass_sh <= 32'd0;
            tnum_sh <= 32'd0;
        end else if (wr) begin
            if (wb_addr == PASS_IDX) begin
                pass_sh <= wb_data;
            end
            if (wb_addr == TNUM_IDX) begin
                tnum_sh <= wb_data;
            end
        end
    end

    // Drain counter: zeroed by the done write, then steps once per DRAIN edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drain_cnt <= 32'd0;
        end else if (clr) begin
            drain_cnt <= 32'd0;
        end else if ((state == S_RUN) && done_wr) begin
            drain_cnt <= 32'd0;
        end else if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt + 32'd1;
        end
    end

    // Capture the test number on the edge a verdict is reached
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fail_testnum <= 32'd0;
        end else if (clr) begin
            fail_testnum <= 32'd0;
        end else if (enter_final) begin
            fail_testnum <= tnum_eff;
        end
    end

    // Saturating statistics counters, live only while the test is running or draining
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_count  <= '0;
            retire_count <= '0;
            jump_count   <= '0;
        end else if (clr) begin
            cycle_count  <= '0;
            retire_count <= '0;
            jump_count   <= '0;
        end else if (active) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (retire && (retire_count != '1)) begin
                retire_count <= retire_count + 1'b1;
            end
            if (jump && (jump_count != '1)) begin
                jump_count <= jump_count + 1'b1;
            end
        end
    end

endmodule
